mipi_bank_arb: RTL and testbench



---
 rtl/mipi_bank_arb_pkg.sv | 19 +
 rtl/mipi_rr_pick.sv | 22 ++
 rtl/mipi_bank_arb.sv | 94 +++++++++
 tb/tb_mipi_bank_arb.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/mipi_bank_arb_pkg.sv
// Shared constants, state encoding and helpers for the MIPI bank arbiter.
package mipi_bank_arb_pkg;

    localparam int MIPI_BANK_NBIT     = 2;
    localparam int MIPI_NREQ          = 4;
    localparam int MIPI_ARB_TO_CYCLES = 50000;

    typedef enum logic [1:0] {
        ARB_IDLE    = 2'd0,
        ARB_ISSUE   = 2'd1,
        ARB_RUN     = 2'd2,
        ARB_RELEASE = 2'd3
    } arb_state_e;

    function automatic logic [MIPI_NREQ-1:0] bank_onehot(input logic [MIPI_BANK_NBIT-1:0] bank);
        return MIPI_NREQ'(1) << bank;
    endfunction

endpackage

// File: rtl/mipi_rr_pick.sv
// Combinational 4-way round-robin picker: first asserted request at or after ptr.
module mipi_rr_pick
    import mipi_bank_arb_pkg::*;
(
    input  logic [MIPI_NREQ-1:0]      req,
    input  logic [MIPI_BANK_NBIT-1:0] ptr,
    output logic                      vld,
    output logic [MIPI_BANK_NBIT-1:0] idx
);

    // Walk from the farthest candidate back to ptr so the nearest one wins.
    always_comb begin
        vld = |req;
        idx = ptr;
        for (int i = MIPI_NREQ - 1; i >= 0; i--) begin
            if (req[ptr + MIPI_BANK_NBIT'(i)]) begin
                idx = ptr + MIPI_BANK_NBIT'(i);
            end
        end
    end

endmodule

// File: rtl/mipi_bank_arb.sv
// Round-robin arbiter/sequencer sharing the MIPI serial engine among four bank requesters.
module mipi_bank_arb
    import mipi_bank_arb_pkg::*;
#(
    parameter int CMD_NBIT  = 16,
    parameter int TO_NBIT   = 16,
    parameter int TO_CYCLES = MIPI_ARB_TO_CYCLES
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [MIPI_NREQ-1:0]          req,
    input  logic [MIPI_NREQ*CMD_NBIT-1:0] req_cmd,
    output logic [MIPI_NREQ-1:0]          gnt,
    output logic [MIPI_NREQ-1:0]          done,
    output logic [MIPI_NREQ-1:0]          err,
    output logic                          eng_start,
    output logic [CMD_NBIT-1:0]           eng_cmd,
    output logic [MIPI_BANK_NBIT-1:0]     eng_bank,
    input  logic                          eng_done,
    output logic                          eng_abort,
    output logic                          busy
);

    localparam logic [TO_NBIT-1:0] TO_LAST = TO_NBIT'(TO_CYCLES - 1);

    arb_state_e                state;
    logic [MIPI_BANK_NBIT-1:0] ptr;
    logic [TO_NBIT-1:0]        to_cnt;
    logic                      pick_vld;
    logic [MIPI_BANK_NBIT-1:0] pick_idx;

    mipi_rr_pick u_pick (
        .req (req),
        .ptr (ptr),
        .vld (pick_vld),
        .idx (pick_idx)
    );

    // Abort is gated by eng_done in the same cycle so a completion on the timeout cycle wins.
    assign eng_abort = (state == ARB_RUN) && (to_cnt == TO_LAST) && !eng_done;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ARB_IDLE;
            ptr       <= '0;
            to_cnt    <= '0;
            gnt       <= '0;
            done      <= '0;
            err       <= '0;
            eng_start <= 1'b0;
            eng_cmd   <= '0;
            eng_bank  <= '0;
            busy      <= 1'b0;
        end else begin
            case (state)
                ARB_IDLE: begin
                    if (pick_vld) begin
                        gnt       <= bank_onehot(pick_idx);
                        eng_cmd   <= req_cmd[int'(pick_idx)*CMD_NBIT +: CMD_NBIT];
                        eng_bank  <= pick_idx;
                        eng_start <= 1'b1;
                        busy      <= 1'b1;
                        state     <= ARB_ISSUE;
                    end
                end
                ARB_ISSUE: begin
                    eng_start <= 1'b0;
                    to_cnt    <= '0;
                    state     <= ARB_RUN;
                end
                ARB_RUN: begin
                    to_cnt <= to_cnt + 1'b1;
                    if (eng_done) begin
                        done  <= bank_onehot(eng_bank);
                        state <= ARB_RELEASE;
                    end else if (to_cnt == TO_LAST) begin
                        err   <= bank_onehot(eng_bank);
                        state <= ARB_RELEASE;
                    end
                end
                ARB_RELEASE: begin
                    done  <= '0;
                    err   <= '0;
                    gnt   <= '0;
                    busy  <= 1'b0;
                    ptr   <= eng_bank + 2'd1;
                    state <= ARB_IDLE;
                end
                default: state <= ARB_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mipi_bank_arb.sv
// Self-checking bench for mipi_bank_arb: directed table, corner sequences and a randomized phase.
module tb_mipi_bank_arb;

    localparam int CMD_NBIT = 16;
    localparam int TO_NBIT  = 16;
    localparam int TO_CYC   = 20;

    logic                   clk = 1'b0;
    logic                   rst_n = 1'b0;
    logic [3:0]             req = '0;
    logic [4*CMD_NBIT-1:0]  req_cmd = '0;
    logic [3:0]             gnt, done, err;
    logic                   eng_start, eng_abort, busy;
    logic [CMD_NBIT-1:0]    eng_cmd;
    logic [1:0]             eng_bank;
    logic                   eng_done = 1'b0;

    int nCompared = 0;
    int nMismatched = 0;
    int cyc = 0;
    logic [CMD_NBIT-1:0] cmdModel [4];

    typedef struct {
        logic [3:0] req;
        int         delay;
        int         expBank;
        bit         expErr;
    } vec_t;

    vec_t vecs[7];

    mipi_bank_arb #(.CMD_NBIT(CMD_NBIT), .TO_NBIT(TO_NBIT), .TO_CYCLES(TO_CYC)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .req_cmd   (req_cmd),
        .gnt       (gnt),
        .done      (done),
        .err       (err),
        .eng_start (eng_start),
        .eng_cmd   (eng_cmd),
        .eng_bank  (eng_bank),
        .eng_done  (eng_done),
        .eng_abort (eng_abort),
        .busy      (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got no completion, expected bench to finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        nCompared++;
        if (act !== exp) begin
            nMismatched++;
            $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic setCmd(input int k, input logic [CMD_NBIT-1:0] c);
        cmdModel[k] = c;
        req_cmd[k*CMD_NBIT +: CMD_NBIT] = c;
    endtask

    task automatic applyStimulus(input logic [3:0] r);
        for (int k = 0; k < 4; k++) setCmd(k, CMD_NBIT'($urandom));
        req = r;
    endtask

    task automatic waitGrant(input int maxCyc, output int waited);
        waited = 0;
        while (gnt == 4'b0 && waited < maxCyc) begin
            tick();
            waited++;
        end
        checkOutput("grant_seen", 32'(gnt != 4'b0), 32'd1);
    endtask

    // Called in the ISSUE cycle; returns in the RELEASE cycle.
    task automatic runTxn(input int expBank, input int delay, input bit expErr,
                          input logic [3:0] reqDuring, output int doneCyc);
        logic [3:0] oh;
        logic [CMD_NBIT-1:0] expCmd;
        oh = 4'(4'b0001 << expBank);
        expCmd = cmdModel[expBank];
        checkOutput("gnt", 32'(gnt), 32'(oh));
        checkOutput("eng_bank", 32'(eng_bank), 32'(expBank));
        checkOutput("eng_cmd", 32'(eng_cmd), 32'(expCmd));
        checkOutput("eng_start", 32'(eng_start), 32'd1);
        checkOutput("busy_issue", 32'(busy), 32'd1);
        req = reqDuring;
        tick();
        checkOutput("eng_start_low", 32'(eng_start), 32'd0);
        for (int c = 1; c <= TO_CYC; c++) begin
            eng_done = (c == delay);
            #1;
            checkOutput("eng_abort", 32'(eng_abort), 32'(c == TO_CYC && delay != c));
            checkOutput("no_early_pulse", 32'({done, err}), 32'd0);
            if (c == delay || c == TO_CYC) break;
            tick();
        end
        doneCyc = cyc;
        tick();
        eng_done = 1'b0;
        checkOutput("done", 32'(done), expErr ? 32'd0 : 32'(oh));
        checkOutput("err", 32'(err), expErr ? 32'(oh) : 32'd0);
        checkOutput("abort_release", 32'(eng_abort), 32'd0);
        checkOutput("gnt_release", 32'(gnt), 32'(oh));
        checkOutput("cmd_hold", 32'(eng_cmd), 32'(expCmd));
        checkOutput("bank_hold", 32'(eng_bank), 32'(expBank));
    endtask

    // Called in RELEASE; moves to IDLE and checks the pulses are gone.
    task automatic finishTxn();
        tick();
        checkOutput("gnt_idle", 32'(gnt), 32'd0);
        checkOutput("done_idle", 32'(done), 32'd0);
        checkOutput("err_idle", 32'(err), 32'd0);
        checkOutput("busy_idle", 32'(busy), 32'd0);
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_gnt"}, 32'(gnt), 32'd0);
        checkOutput({tag, "_done"}, 32'(done), 32'd0);
        checkOutput({tag, "_err"}, 32'(err), 32'd0);
        checkOutput({tag, "_start"}, 32'(eng_start), 32'd0);
        checkOutput({tag, "_cmd"}, 32'(eng_cmd), 32'd0);
        checkOutput({tag, "_bank"}, 32'(eng_bank), 32'd0);
        checkOutput({tag, "_abort"}, 32'(eng_abort), 32'd0);
        checkOutput({tag, "_busy"}, 32'(busy), 32'd0);
    endtask

    initial begin
        int w, dc, mdlPtr, win, delay;
        logic [3:0] r;

        vecs[0] = '{4'b0100, 10, 2, 1'b0};
        vecs[1] = '{4'b0011,  4, 0, 1'b0};
        vecs[2] = '{4'b1001,  1, 3, 1'b0};
        vecs[3] = '{4'b0010,  0, 1, 1'b1};
        vecs[4] = '{4'b0101,  7, 2, 1'b0};
        vecs[5] = '{4'b0110,  3, 1, 1'b0};
        vecs[6] = '{4'b1000, TO_CYC, 3, 1'b0};

        #1;
        checkAllZero("reset");
        tick();
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < 7; i++) begin
            applyStimulus(vecs[i].req);
            if (i == 0) setCmd(2, 16'hA5C3);
            waitGrant(4, w);
            checkOutput("grant_latency", 32'(w), 32'd1);
            runTxn(vecs[i].expBank, vecs[i].delay, vecs[i].expErr, vecs[i].req, dc);
            req = 4'b0;
            finishTxn();
        end

        // Fairness with all four requests held.
        applyStimulus(4'b1111);
        waitGrant(4, w);
        for (int g = 0; g < 5; g++) begin
            runTxn(g % 4, 5, 1'b0, 4'b1111, dc);
            if (g < 4) begin
                tick();
                checkOutput("gnt_gap", 32'(gnt), 32'd0);
                waitGrant(4, w);
                checkOutput("turnaround", 32'(cyc - dc), 32'd3);
            end
        end
        req = 4'b0;
        finishTxn();

        // Request withdrawn right after grant.
        applyStimulus(4'b1000);
        waitGrant(4, w);
        runTxn(3, 6, 1'b0, 4'b0000, dc);
        finishTxn();
        for (int k = 0; k < 4; k++) begin
            tick();
            checkOutput("no_regrant", 32'(gnt), 32'd0);
        end

        // Reset in the middle of RUN.
        applyStimulus(4'b0100);
        waitGrant(4, w);
        tick();
        tick();
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        checkAllZero("midrun_reset");
        applyStimulus(4'b1001);
        tick();
        tick();
        @(negedge clk);
        rst_n = 1'b1;
        checkOutput("post_reset_pulses", 32'({done, err, eng_abort}), 32'd0);
        waitGrant(4, w);
        runTxn(0, 3, 1'b0, 4'b1001, dc);
        req = 4'b0;
        finishTxn();

        // Randomized traffic against a plain round-robin model.
        mdlPtr = 1;
        for (int t = 0; t < 30; t++) begin
            r = 4'($urandom_range(1, 15));
            win = -1;
            for (int i = 0; i < 4; i++) begin
                if (win < 0 && r[(mdlPtr + i) % 4]) win = (mdlPtr + i) % 4;
            end
            delay = $urandom_range(1, TO_CYC + 4);
            applyStimulus(r);
            waitGrant(4, w);
            runTxn(win, delay, delay > TO_CYC, r, dc);
            req = 4'b0;
            finishTxn();
            mdlPtr = (win + 1) % 4;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
